// File: rtl/integrator_sched.sv
// integrator_sched: time-shares one integrator between NUM_REQ voices (warm-up, run, drain gap).
// Define INTEGRATOR_SCHED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module integrator_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int PIPE_LAT     = 3,
    parameter int DATA_W       = 16
) (
    input  logic                              clk_in,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    freq_req,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [$clog2(NUM_REQ)-1:0]        owner,
    output logic                              int_enable,
    output logic [DATA_W-1:0]                 int_freq,
    output logic                              out_valid,
    output logic                              busy
);
    localparam int OW   = $clog2(NUM_REQ);
    localparam int CMAX = (DWELL_CYCLES > PIPE_LAT + 1) ? DWELL_CYCLES : PIPE_LAT + 1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] WARM_LAST  = CW'(PIPE_LAT);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CMAX);

    typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   base;
    logic [OW-1:0]   win_idx;
    logic            win_ok;
    logic            dwell_done;

`ifdef INTEGRATOR_SCHED_PRIO_EN
    assign base = '0;
`else
    logic [OW-1:0]   rr_ptr;
    assign base = rr_ptr;
`endif

    // First set request found when scanning upward from base, wrapping at NUM_REQ.
    always_comb begin
        int k;
        logic [OW-1:0] kk;
        win_ok  = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(base) + i;
            k = (k >= NUM_REQ) ? k - NUM_REQ : k;
            kk = OW'(k);
            if (!win_ok && req[kk]) begin
                win_ok  = 1'b1;
                win_idx = kk;
            end
        end
    end

    assign dwell_done = (DWELL_CYCLES != 0) && (cnt == DWELL_LAST);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            int_enable <= 1'b0;
            int_freq   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
`ifndef INTEGRATOR_SCHED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (win_ok) begin
                    state      <= WARM;
                    gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    owner      <= win_idx;
                    int_freq   <= freq_req[win_idx];
                    int_enable <= 1'b1;
                    busy       <= 1'b1;
                    cnt        <= '0;
                end
                WARM: if (!req[owner]) begin
                    state      <= DRAIN;
                    gnt        <= '0;
                    int_enable <= 1'b0;
                end else if (cnt == WARM_LAST) begin
                    state      <= RUN;
                    out_valid  <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt        <= cnt + CW'(1);
                end
                RUN: if (!req[owner] || dwell_done) begin
                    state      <= DRAIN;
                    gnt        <= '0;
                    int_enable <= 1'b0;
                    out_valid  <= 1'b0;
                end else if (cnt != CNT_SAT) begin
                    cnt        <= cnt + CW'(1);
                end
                DRAIN: begin
                    // The one-cycle low enable lets the integrator clear before the next owner.
                    state      <= IDLE;
                    busy       <= 1'b0;
`ifndef INTEGRATOR_SCHED_PRIO_EN
                    rr_ptr     <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_integrator_sched.sv
// tb_integrator_sched: directed checks of integrator_sched with NUM_REQ=4, DWELL_CYCLES=8, PIPE_LAT=3.
module tb_integrator_sched;
    logic              clk_in = 1'b0;
    logic              reset_n = 1'b1;
    logic [3:0]        req = '0;
    logic [3:0][15:0]  freq_req;
    logic [3:0]        gnt;
    logic [1:0]        owner;
    logic              int_enable;
    logic [15:0]       int_freq;
    logic              out_valid;
    logic              busy;
    int                errors = 0;
    int                checks = 0;

    integrator_sched #(.NUM_REQ(4), .DWELL_CYCLES(8), .PIPE_LAT(3), .DATA_W(16)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .req(req), .freq_req(freq_req),
        .gnt(gnt), .owner(owner), .int_enable(int_enable), .int_freq(int_freq),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_owner"}, 32'(owner), 0);
        chk({tag, "_en"}, 32'(int_enable), 0);
        chk({tag, "_freq"}, 32'(int_freq), 0);
        chk({tag, "_ov"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n;
        int ov;
        int exp_own [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) freq_req[i] = 16'(16'h1111 * (i + 1));
        // asynchronous reset, before any clock edge
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rst");
        step();
        step();
        chk_all_zero("rst_hold");
        @(negedge clk_in) reset_n = 1'b1;
        step();

        // all requesting: round-robin 0,1,2,3,0 with 8 valid cycles each
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (gnt == 0 && n < 20) begin step(); n++; end
            chk($sformatf("t2_grant%0d", g), 32'(gnt), 32'(4'b0001 << exp_own[g]));
            chk($sformatf("t2_owner%0d", g), 32'(owner), 32'(exp_own[g]));
            chk($sformatf("t2_freq%0d", g), 32'(int_freq), 32'(16'h1111 * (exp_own[g] + 1)));
            ov = 0;
            n = 0;
            while (gnt != 0 && n < 30) begin
                if (out_valid) ov++;
                step();
                n++;
            end
            chk($sformatf("t2_ovcnt%0d", g), 32'(ov), 8);
            chk($sformatf("t2_gap_en%0d", g), 32'(int_enable), 0);
        end
        req = 4'b0000;
        step();
        step();
        chk("t2_idle_busy", 32'(busy), 0);

        // single requester: exact cycle timeline and re-grant after DRAIN+IDLE
        req = 4'b0010;
        chk("t1_c0_gnt", 32'(gnt), 0);
        for (int c = 1; c <= 15; c++) begin
            step();
            chk($sformatf("t1_gnt@c%0d", c), 32'(gnt), (c <= 12 || c == 15) ? 32'h2 : 32'h0);
            chk($sformatf("t1_en@c%0d", c), 32'(int_enable), 32'(c <= 12 || c == 15));
            chk($sformatf("t1_ov@c%0d", c), 32'(out_valid), 32'(c >= 5 && c <= 12));
            chk($sformatf("t1_busy@c%0d", c), 32'(busy), 32'(c != 14));
            if (c == 1) chk("t1_freq", 32'(int_freq), 32'h2222);
        end
        req = 4'b0000;
        step();
        step();
        chk("t1_end_gnt", 32'(gnt), 0);
        chk("t1_end_busy", 32'(busy), 0);

        // drop at 4th RUN cycle
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) chk("t3_gnt", 32'(gnt), 32'h4);
        end
        chk("t3_ov_c8", 32'(out_valid), 1);
        req = 4'b0000;
        step();
        chk("t3_drain_gnt", 32'(gnt), 0);
        chk("t3_drain_en", 32'(int_enable), 0);
        chk("t3_drain_ov", 32'(out_valid), 0);
        chk("t3_drain_busy", 32'(busy), 1);
        step();
        chk("t3_idle_busy", 32'(busy), 0);
        repeat (3) step();
        chk("t3_nogrant", 32'(gnt), 0);
        chk("t3_still_idle", 32'(busy), 0);

        // drop in the 2nd WARM cycle
        req = 4'b0001;
        step();
        chk("t4_gnt", 32'(gnt), 32'h1);
        chk("t4_ov_c1", 32'(out_valid), 0);
        step();
        chk("t4_ov_c2", 32'(out_valid), 0);
        req = 4'b0000;
        step();
        chk("t4_drain_gnt", 32'(gnt), 0);
        chk("t4_drain_en", 32'(int_enable), 0);
        chk("t4_drain_busy", 32'(busy), 1);
        chk("t4_ov_c3", 32'(out_valid), 0);
        step();
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_ov_c4", 32'(out_valid), 0);

        // reset during RUN; rr_ptr must return to 0
        req = 4'b1000;
        repeat (6) step();
        chk("t5_run_ov", 32'(out_valid), 1);
        chk("t5_run_gnt", 32'(gnt), 32'h8);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("t5_rst");
        step();
        chk("t5_rst_hold_gnt", 32'(gnt), 0);
        req = 4'b1001;
        @(negedge clk_in) reset_n = 1'b1;
        step();
        chk("t5_regrant_gnt", 32'(gnt), 32'h1);
        chk("t5_regrant_owner", 32'(owner), 0);
        chk("t5_regrant_freq", 32'(int_freq), 32'h1111);
        req = 4'b0000;
        step();
        step();
        chk("t5_idle_busy", 32'(busy), 0);

        // freq latched at grant; next owner depends on arbitration mode
        req = 4'b1010;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 1) chk("t6_gnt", 32'(gnt), 32'h2);
            if (c == 1) chk("t6_freq", 32'(int_freq), 32'h2222);
            if (c == 6) freq_req[1] = 16'hABCD;
            if (c == 12) chk("t6_freq_held", 32'(int_freq), 32'h2222);
            if (c == 13) chk("t6_drain_gnt", 32'(gnt), 0);
        end
`ifdef INTEGRATOR_SCHED_PRIO_EN
        chk("t6_next_gnt", 32'(gnt), 32'h2);
        chk("t6_next_freq", 32'(int_freq), 32'hABCD);
`else
        chk("t6_next_gnt", 32'(gnt), 32'h8);
        chk("t6_next_freq", 32'(int_freq), 32'h4444);
`endif
        req = 4'b0000;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
